// File: rtl/nexys_starship_pkg.sv
// Shared types and constants for the starship shield-break scheduler.
// State encodings, shield indices, default parameters and the one-hot helper.
package nexys_starship_pkg;

    typedef enum logic [3:0] {
        StIdle  = 4'b0001,
        StArmed = 4'b0010,
        StPick  = 4'b0100,
        StFire  = 4'b1000
    } state_e;

    localparam int unsigned ShieldUp    = 3;
    localparam int unsigned ShieldDown  = 2;
    localparam int unsigned ShieldLeft  = 1;
    localparam int unsigned ShieldRight = 0;

    localparam int unsigned DefBaseInterval  = 8;
    localparam int unsigned DefMinInterval   = 2;
    localparam int unsigned DefLevelBreaks   = 4;
    localparam int unsigned DefOverloadTicks = 6;

    localparam logic [15:0] LfsrSeed = 16'hACE1;
    localparam logic [2:0]  LevelMax = 3'd7;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/nexys_starship_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running in every state.
// Seeded non-zero, so the maximal-length sequence never reaches the all-zero lockup.
module nexys_starship_lfsr
    import nexys_starship_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    output logic [15:0] value_o
);

    logic [15:0] lfsr_q;
    logic        feedback;

    assign feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            lfsr_q <= LfsrSeed;
        end else begin
            lfsr_q <= {lfsr_q[14:0], feedback};
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/nexys_starship_break_sched.sv
// Shield-break scheduler: counts game ticks, picks an intact shield, pulses break_req.
// Optional overload detector enabled by defining STARSHIP_OVERLOAD_EN. Reset release is
// expected to be synchronised to Clk upstream.
module nexys_starship_break_sched
    import nexys_starship_pkg::*;
#(
    parameter int unsigned BASE_INTERVAL  = DefBaseInterval,
    parameter int unsigned MIN_INTERVAL   = DefMinInterval,
    parameter int unsigned LEVEL_BREAKS   = DefLevelBreaks,
    parameter int unsigned OVERLOAD_TICKS = DefOverloadTicks
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       timer_tick,
    input  logic       play_flag,
    input  logic       gameover_ctrl,
    input  logic [3:0] shield_broken,
    output logic [3:0] break_req,
    output logic [3:0] break_combo,
    output logic [2:0] level,
    output logic       q_Idle,
    output logic       q_Armed,
    output logic       q_Pick,
    output logic       q_Fire,
    output logic       overload
);

    localparam int unsigned TickW = $clog2(BASE_INTERVAL + 1);
    localparam int unsigned IssW  = $clog2(LEVEL_BREAKS + 1);

    state_e           state_q;
    logic [TickW-1:0] tick_cnt_q;
    logic [IssW-1:0]  issue_cnt_q;
    logic [2:0]       level_q;
    logic [1:0]       target_q;
    logic [3:0]       break_req_q;
    logic [3:0]       break_combo_q;

    logic [15:0] lfsr;
    logic [31:0] interval;
    logic        tick_last;
    logic        issue_last;
    logic [1:0]  pick_idx;
    logic [1:0]  cand;
    logic        pick_found;

    nexys_starship_lfsr u_lfsr (
        .Clk    (Clk),
        .Reset  (Reset),
        .value_o(lfsr)
    );

    logic unused_lfsr_bits;
    assign unused_lfsr_bits = ^{lfsr[15:8], lfsr[3:2]};

    // Compare before subtracting so the interval never wraps below the floor.
    always_comb begin
        interval = MIN_INTERVAL;
        if (BASE_INTERVAL > 32'(level_q) + MIN_INTERVAL) begin
            interval = BASE_INTERVAL - 32'(level_q);
        end
    end

    assign tick_last  = (tick_cnt_q == TickW'(interval - 1));
    assign issue_last = (issue_cnt_q == IssW'(LEVEL_BREAKS - 1));

    // Descending scan so the first intact shield from lfsr[1:0] upward wins.
    always_comb begin
        pick_idx   = lfsr[1:0];
        pick_found = 1'b0;
        cand       = '0;
        for (int i = 3; i >= 0; i--) begin
            cand = lfsr[1:0] + 2'(i);
            if (!shield_broken[cand]) begin
                pick_idx   = cand;
                pick_found = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= StIdle;
            tick_cnt_q    <= '0;
            issue_cnt_q   <= '0;
            level_q       <= '0;
            target_q      <= '0;
            break_req_q   <= '0;
            break_combo_q <= '0;
        end else begin
            break_req_q <= '0;
            if (gameover_ctrl) begin
                state_q     <= StIdle;
                tick_cnt_q  <= '0;
                issue_cnt_q <= '0;
                level_q     <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (play_flag) begin
                            state_q    <= StArmed;
                            tick_cnt_q <= '0;
                        end
                    end
                    StArmed: begin
                        if (timer_tick) begin
                            if (tick_last) begin
                                state_q    <= StPick;
                                tick_cnt_q <= '0;
                            end else begin
                                tick_cnt_q <= tick_cnt_q + 1'b1;
                            end
                        end
                    end
                    StPick: begin
                        if (pick_found) begin
                            target_q <= pick_idx;
                            state_q  <= StFire;
                        end else begin
                            state_q <= StArmed;
                        end
                    end
                    StFire: begin
                        break_req_q   <= onehot4(target_q);
                        break_combo_q <= lfsr[7:4];
                        state_q       <= StArmed;
                        if (issue_last) begin
                            issue_cnt_q <= '0;
                            if (level_q != LevelMax) begin
                                level_q <= level_q + 1'b1;
                            end
                        end else begin
                            issue_cnt_q <= issue_cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifdef STARSHIP_OVERLOAD_EN
    localparam int unsigned OvlW = $clog2(OVERLOAD_TICKS + 1);

    logic [OvlW-1:0] ovl_cnt_q;
    logic            overload_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ovl_cnt_q  <= '0;
            overload_q <= 1'b0;
        end else begin
            overload_q <= 1'b0;
            if (state_q == StIdle || shield_broken != 4'b1111) begin
                ovl_cnt_q <= '0;
            end else if (timer_tick && (state_q == StArmed || state_q == StPick)) begin
                if (ovl_cnt_q == OvlW'(OVERLOAD_TICKS - 1)) begin
                    ovl_cnt_q  <= '0;
                    overload_q <= 1'b1;
                end else begin
                    ovl_cnt_q <= ovl_cnt_q + 1'b1;
                end
            end
        end
    end

    assign overload = overload_q;
`else
    logic unused_ovl_cfg;
    assign unused_ovl_cfg = ^32'(OVERLOAD_TICKS);
    assign overload       = 1'b0;
`endif

    assign break_req   = break_req_q;
    assign break_combo = break_combo_q;
    assign level       = level_q;
    assign q_Idle      = state_q[0];
    assign q_Armed     = state_q[1];
    assign q_Pick      = state_q[2];
    assign q_Fire      = state_q[3];

endmodule

// File: tb/tb_nexys_starship_break_sched.sv
// Directed self-checking bench for nexys_starship_break_sched.
// Define STARSHIP_OVERLOAD_EN for both bench and RTL to check the overload build.
module tb_nexys_starship_break_sched;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       timer_tick = 1'b0;
    logic       play_flag = 1'b0;
    logic       gameover_ctrl = 1'b0;
    logic [3:0] shield_broken = 4'b0000;
    logic [3:0] break_req;
    logic [3:0] break_combo;
    logic [2:0] level;
    logic       q_Idle;
    logic       q_Armed;
    logic       q_Pick;
    logic       q_Fire;
    logic       overload;
    logic [3:0] st;

    int total = 0;
    int bad = 0;

    logic [15:0] m_lfsr;

    nexys_starship_break_sched dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .timer_tick   (timer_tick),
        .play_flag    (play_flag),
        .gameover_ctrl(gameover_ctrl),
        .shield_broken(shield_broken),
        .break_req    (break_req),
        .break_combo  (break_combo),
        .level        (level),
        .q_Idle       (q_Idle),
        .q_Armed      (q_Armed),
        .q_Pick       (q_Pick),
        .q_Fire       (q_Fire),
        .overload     (overload)
    );

    always #5 Clk = ~Clk;

    assign st = {q_Idle, q_Armed, q_Pick, q_Fire};

    // Reference LFSR: taps 16,14,13,11, seed ACE1.
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) m_lfsr <= 16'hACE1;
        else m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic logic [3:0] exp_pick(input logic [1:0] base, input logic [3:0] sb);
        logic [1:0] idx;
        for (int i = 0; i < 4; i++) begin
            idx = base + 2'(i);
            if (!sb[idx]) return 4'b0001 << idx;
        end
        return 4'b0000;
    endfunction

    task automatic reset_play(input logic [3:0] sb);
        @(negedge Clk);
        Reset = 1'b0;
        timer_tick = 1'b0;
        play_flag = 1'b0;
        gameover_ctrl = 1'b0;
        shield_broken = sb;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        play_flag = 1'b1;
        @(negedge Clk);
        play_flag = 1'b0;
    endtask

    // Drives ticks every 'period' cycles until a break pulse (or FIRE when stop_at_fire).
    task automatic wait_break(input int period, input bit stop_at_fire, input int max_cyc,
                              output int ticks, output int cyc, output logic [3:0] req,
                              output logic [3:0] req_after, output logic [3:0] exp_req,
                              output logic [3:0] exp_combo, output logic [1:0] pick_base,
                              output bit ok);
        ticks = 0; cyc = -1; req = '0; req_after = '0; exp_req = '0; exp_combo = '0;
        pick_base = '0; ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            timer_tick = (c % period == 0);
            if (q_Armed && timer_tick) ticks++;
            @(negedge Clk);
            if (q_Pick) begin
                pick_base = m_lfsr[1:0];
                exp_req = exp_pick(m_lfsr[1:0], shield_broken);
            end
            if (q_Fire) begin
                exp_combo = m_lfsr[7:4];
                if (stop_at_fire) begin
                    timer_tick = 1'b0;
                    cyc = c;
                    ok = 1'b1;
                    return;
                end
            end
            if (break_req != 4'b0000) begin
                req = break_req;
                cyc = c;
                timer_tick = 1'b0;
                @(negedge Clk);
                req_after = break_req;
                ok = 1'b1;
                return;
            end
        end
        timer_tick = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge Clk);
        total++; if (st !== 4'b1000) begin bad++; $display("FAIL reset_state: got %b want 1000", st); end
        total++; if (break_req !== 4'b0) begin bad++; $display("FAIL reset_req: got %b want 0000", break_req); end
        total++; if (break_combo !== 4'b0) begin bad++; $display("FAIL reset_combo: got %h want 0", break_combo); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
        total++; if (overload !== 1'b0) begin bad++; $display("FAIL reset_overload: got %b want 0", overload); end
        Reset = 1'b1;
        for (int c = 0; c < 12; c++) begin
            timer_tick = (c % 4 == 0);
            @(negedge Clk);
        end
        timer_tick = 1'b0;
        total++; if (st !== 4'b1000) begin bad++; $display("FAIL idle_hold: got %b want 1000", st); end
    endtask

    task automatic test_first_break;
        int ticks, cyc; logic [3:0] req, req_after, exp_req, exp_combo; logic [1:0] pb; bit ok;
        reset_play(4'b0000);
        total++; if (st !== 4'b0100) begin bad++; $display("FAIL armed_entry: got %b want 0100", st); end
        wait_break(4, 1'b0, 200, ticks, cyc, req, req_after, exp_req, exp_combo, pb, ok);
        total++; if (!ok) begin bad++; $display("FAIL first_seen: got none want pulse"); end
        total++; if (ticks !== 8) begin bad++; $display("FAIL first_ticks: got %0d want 8", ticks); end
        total++; if (cyc !== 30) begin bad++; $display("FAIL first_latency: got %0d want 30", cyc); end
        total++; if (req !== exp_req) begin bad++; $display("FAIL first_req: got %b want %b", req, exp_req); end
        total++; if ($onehot(req) !== 1'b1) begin bad++; $display("FAIL first_onehot: got %b", req); end
        total++; if (req_after !== 4'b0) begin bad++; $display("FAIL first_width: got %b want 0000", req_after); end
        total++; if (break_combo !== exp_combo) begin bad++; $display("FAIL first_combo: got %h want %h", break_combo, exp_combo); end
    endtask

    task automatic test_tick_in_pick;
        int ticks, cyc; logic [3:0] req, req_after, exp_req, exp_combo; logic [1:0] pb; bit ok;
        reset_play(4'b0000);
        for (int k = 0; k < 2; k++) begin
            wait_break(1, 1'b0, 100, ticks, cyc, req, req_after, exp_req, exp_combo, pb, ok);
            total++; if (cyc !== 9) begin bad++; $display("FAIL tick_ignore_latency[%0d]: got %0d want 9", k, cyc); end
        end
    endtask

    task automatic test_level;
        int ticks, cyc, exp_lvl; logic [3:0] req, req_after, exp_req, exp_combo; logic [1:0] pb; bit ok;
        reset_play(4'b0000);
        for (int k = 1; k <= 32; k++) begin
            wait_break(4, 1'b0, 200, ticks, cyc, req, req_after, exp_req, exp_combo, pb, ok);
            exp_lvl = (k / 4 > 7) ? 7 : k / 4;
            total++; if (req !== exp_req) begin bad++; $display("FAIL lvl_req[%0d]: got %b want %b", k, req, exp_req); end
            total++; if (level !== 3'(exp_lvl)) begin bad++; $display("FAIL lvl_level[%0d]: got %0d want %0d", k, level, exp_lvl); end
            if (k == 5) begin
                total++; if (ticks !== 7 || cyc !== 26) begin bad++; $display("FAIL lvl1_interval: got ticks=%0d cyc=%0d want 7/26", ticks, cyc); end
            end
            if (k == 32) begin
                total++; if (ticks !== 2 || cyc !== 6) begin bad++; $display("FAIL lvl7_interval: got ticks=%0d cyc=%0d want 2/6", ticks, cyc); end
            end
        end
    endtask

    task automatic test_skip_broken;
        int ticks, cyc; logic [3:0] req, req_after, exp_req, exp_combo; logic [1:0] pb; bit ok;
        bit seen = 1'b0;
        shield_broken = 4'b0100;
        for (int k = 0; k < 40; k++) begin
            wait_break(4, 1'b0, 200, ticks, cyc, req, req_after, exp_req, exp_combo, pb, ok);
            total++; if (req !== exp_req || req[2] !== 1'b0) begin bad++; $display("FAIL skip_req[%0d]: got %b want %b", k, req, exp_req); end
            if (pb == 2'd2) begin
                seen = 1'b1;
                total++; if (req !== 4'b1000) begin bad++; $display("FAIL skip_idx3: got %b want 1000", req); end
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL skip_case_seen: got 0 want 1"); end
        shield_broken = 4'b0000;
    endtask

    task automatic test_all_broken;
        int ticks = 0, nbrk = 0, novl = 0, ovl_tick = -1;
        bit saw_pick = 1'b0, prev_pick = 1'b0, bad_ret = 1'b0;
        reset_play(4'b1111);
        for (int c = 0; c < 44; c++) begin
            timer_tick = (c % 4 == 0);
            if (q_Armed && timer_tick) ticks++;
            @(negedge Clk);
            if (break_req != 4'b0) nbrk++;
            if (q_Pick) saw_pick = 1'b1;
            if (prev_pick && !q_Armed) bad_ret = 1'b1;
            prev_pick = q_Pick;
            if (overload) begin novl++; ovl_tick = ticks; end
        end
        timer_tick = 1'b0;
        total++; if (nbrk !== 0) begin bad++; $display("FAIL allbrk_req: got %0d pulses want 0", nbrk); end
        total++; if (!saw_pick || bad_ret) begin bad++; $display("FAIL allbrk_return: got pick=%0d badret=%0d want 1/0", saw_pick, bad_ret); end
`ifdef STARSHIP_OVERLOAD_EN
        total++; if (novl !== 1) begin bad++; $display("FAIL overload_count: got %0d want 1", novl); end
        total++; if (ovl_tick !== 6) begin bad++; $display("FAIL overload_tick: got %0d want 6", ovl_tick); end
`else
        total++; if (novl !== 0) begin bad++; $display("FAIL overload_off: got %0d want 0", novl); end
`endif
        shield_broken = 4'b0000;
    endtask

    task automatic test_gameover_fire;
        int ticks, cyc; logic [3:0] req, req_after, exp_req, exp_combo, combo_prev; logic [1:0] pb; bit ok;
        reset_play(4'b0000);
        for (int k = 0; k < 4; k++) begin
            wait_break(4, 1'b0, 200, ticks, cyc, req, req_after, exp_req, exp_combo, pb, ok);
        end
        combo_prev = break_combo;
        total++; if (level !== 3'd1) begin bad++; $display("FAIL go_pre_level: got %0d want 1", level); end
        wait_break(4, 1'b1, 200, ticks, cyc, req, req_after, exp_req, exp_combo, pb, ok);
        total++; if (!ok) begin bad++; $display("FAIL go_fire_seen: got none want FIRE"); end
        gameover_ctrl = 1'b1;
        @(negedge Clk);
        gameover_ctrl = 1'b0;
        total++; if (break_req !== 4'b0) begin bad++; $display("FAIL go_req: got %b want 0000", break_req); end
        total++; if (st !== 4'b1000) begin bad++; $display("FAIL go_state: got %b want 1000", st); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL go_level: got %0d want 0", level); end
        total++; if (break_combo !== combo_prev) begin bad++; $display("FAIL go_combo: got %h want %h", break_combo, combo_prev); end
        @(negedge Clk);
        total++; if (break_req !== 4'b0 || st !== 4'b1000) begin bad++; $display("FAIL go_after: got req=%b st=%b want 0000/1000", break_req, st); end
    endtask

    task automatic test_reset_mid_pulse;
        int ticks, cyc; logic [3:0] req, req_after, exp_req, exp_combo; logic [1:0] pb; bit ok;
        reset_play(4'b0000);
        wait_break(4, 1'b1, 200, ticks, cyc, req, req_after, exp_req, exp_combo, pb, ok);
        @(negedge Clk);
        total++; if (break_req !== exp_req || exp_req == 4'b0) begin bad++; $display("FAIL rst_pre_pulse: got %b want %b", break_req, exp_req); end
        #2;
        Reset = 1'b0;
        #1;
        total++; if (break_req !== 4'b0) begin bad++; $display("FAIL rst_req: got %b want 0000", break_req); end
        total++; if (st !== 4'b1000) begin bad++; $display("FAIL rst_state: got %b want 1000", st); end
        total++; if (break_combo !== 4'b0 || level !== 3'd0 || overload !== 1'b0) begin
            bad++; $display("FAIL rst_outputs: got combo=%h level=%0d ovl=%b want 0/0/0", break_combo, level, overload);
        end
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_first_break();
        test_tick_in_pick();
        test_level();
        test_skip_broken();
        test_all_broken();
        test_gameover_fire();
        test_reset_mid_pulse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
